// File: rtl/wb_seven_seg_display_pkg.sv
// Shared definitions for the writeback seven-segment observer.
//   - Display idle constants (all segments / all anodes dark, active-low).
//   - Scan FSM state encoding.
//   - Hex digit segment patterns {g,f,e,d,c,b,a}, active-low, plus a lookup function.
package wb_seven_seg_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Digit that carries the decimal point: it separates the PC half (digits 7..4)
  // from the data half (digits 3..0).
  localparam logic [2:0] DP_DIGIT  = 3'd4;

  typedef enum logic {
    BLANK = 1'b0,
    LIT   = 1'b1
  } state_t;

  localparam logic [6:0] HEX_0 = 7'h40;
  localparam logic [6:0] HEX_1 = 7'h79;
  localparam logic [6:0] HEX_2 = 7'h24;
  localparam logic [6:0] HEX_3 = 7'h30;
  localparam logic [6:0] HEX_4 = 7'h19;
  localparam logic [6:0] HEX_5 = 7'h12;
  localparam logic [6:0] HEX_6 = 7'h02;
  localparam logic [6:0] HEX_7 = 7'h78;
  localparam logic [6:0] HEX_8 = 7'h00;
  localparam logic [6:0] HEX_9 = 7'h10;
  localparam logic [6:0] HEX_A = 7'h08;
  localparam logic [6:0] HEX_B = 7'h03;
  localparam logic [6:0] HEX_C = 7'h46;
  localparam logic [6:0] HEX_D = 7'h21;
  localparam logic [6:0] HEX_E = 7'h06;
  localparam logic [6:0] HEX_F = 7'h0E;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = HEX_0;
      4'h1: pat = HEX_1;
      4'h2: pat = HEX_2;
      4'h3: pat = HEX_3;
      4'h4: pat = HEX_4;
      4'h5: pat = HEX_5;
      4'h6: pat = HEX_6;
      4'h7: pat = HEX_7;
      4'h8: pat = HEX_8;
      4'h9: pat = HEX_9;
      4'hA: pat = HEX_A;
      4'hB: pat = HEX_B;
      4'hC: pat = HEX_C;
      4'hD: pat = HEX_D;
      4'hE: pat = HEX_E;
      default: pat = HEX_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/wb_seven_seg_display_hex_to_7seg.sv
// hex_to_7seg: combinational nibble to seven-segment decoder.
//   nibble  in  4  hex value 0..F
//   seg     out 7  {g,f,e,d,c,b,a}, active-low
module hex_to_7seg
  import wb_seven_seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_seg(nibble);

endmodule

// File: rtl/wb_seven_seg_display.sv
// wb_seven_seg_display: captures each register-file writeback (PC + data) of the
// core and scans it onto an 8-digit multiplexed seven-segment display in hex.
// Digits 3..0 show the data half, digits 7..4 the PC half (show_hi picks bits
// [31:16] instead of [15:0]). Every digit is preceded by one dark clock to stop
// ghosting, then stays lit for REFRESH_DIV clocks.
// Ports:
//   clk       in   1       system clock
//   reset     in   1       synchronous, active-high
//   wb_valid  in   1       register file written this cycle
//   pc_in     in   DATA_W  PC of the writing instruction
//   wb_data   in   DATA_W  value written
//   freeze    in   1       hold the current capture, ignore wb_valid
//   show_hi   in   1       0 = bits [15:0], 1 = bits [31:16]
//   an        out  8       digit anodes, active-low
//   seg       out  7       segments {g,f,e,d,c,b,a}, active-low
//   dp        out  1       decimal point, active-low
//   wb_count  out  8       captures since reset, wraps 255 -> 0
module wb_seven_seg_display
  import wb_seven_seg_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              freeze,
  input  logic              show_hi,
  output logic [7:0]        an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [7:0]        wb_count
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DATA_W-1:0] pc_reg;
  logic [DATA_W-1:0] data_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic [2:0]        digit_reg;
  state_t            state_reg;

  logic              tick;
  logic [31:0]       pc_ext;
  logic [31:0]       data_ext;
  logic [15:0]       pc_half;
  logic [15:0]       data_half;
  logic [3:0]        digit_nib [8];
  logic [3:0]        nib_sel;
  logic [6:0]        seg_next;
  logic [7:0]        an_next;

  assign tick = (div_cnt_reg == DIV_LAST);

  // Normalise the captures to 32 bits so the half select is well defined for
  // any DATA_W (narrower values read as zero in the upper half).
  assign pc_ext    = 32'(pc_reg);
  assign data_ext  = 32'(data_reg);
  assign pc_half   = show_hi ? pc_ext[31:16]   : pc_ext[15:0];
  assign data_half = show_hi ? data_ext[31:16] : data_ext[15:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign digit_nib[gi]     = data_half[4*gi +: 4];
      assign digit_nib[gi + 4] = pc_half[4*gi +: 4];
    end
    for (gi = 0; gi < 8; gi++) begin : g_an
      assign an_next[gi] = (digit_reg != 3'(gi));
    end
  endgenerate

  assign nib_sel = digit_nib[digit_reg];

  hex_to_7seg u_hex_to_7seg (
    .nibble (nib_sel),
    .seg    (seg_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg      <= '0;
      data_reg    <= '0;
      wb_count    <= 8'd0;
      div_cnt_reg <= '0;
      digit_reg   <= 3'd0;
      state_reg   <= BLANK;
      an          <= AN_OFF;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
    end else begin
      if (wb_valid && !freeze) begin
        pc_reg   <= pc_in;
        data_reg <= wb_data;
        wb_count <= wb_count + 8'd1;
      end

      case (state_reg)
        BLANK: begin
          // The digit is latched from this cycle's captures; a capture on the
          // same edge only shows up from the next digit onward.
          state_reg   <= LIT;
          div_cnt_reg <= '0;
          an          <= an_next;
          seg         <= seg_next;
          dp          <= (digit_reg != DP_DIGIT);
        end
        LIT: begin
          // The divider restarts with each lit period so every digit gets
          // exactly REFRESH_DIV lit clocks regardless of the dark cycle.
          if (tick) begin
            state_reg   <= BLANK;
            div_cnt_reg <= '0;
            digit_reg   <= digit_reg + 3'd1;
            an          <= AN_OFF;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end
        default: begin
          state_reg <= BLANK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_seven_seg_display.sv
// Directed bench for wb_seven_seg_display with REFRESH_DIV=4.
module tb_wb_seven_seg_display;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic [31:0] pc_in;
  logic [31:0] wb_data;
  logic        freeze;
  logic        show_hi;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  wb_count;

  int n_checks = 0;
  int n_errors = 0;

  wb_seven_seg_display #(
    .REFRESH_DIV (4),
    .DATA_W      (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_valid (wb_valid),
    .pc_in    (pc_in),
    .wb_data  (wb_data),
    .freeze   (freeze),
    .show_hi  (show_hi),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .wb_count (wb_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          pulses;
    logic        frz;
    logic        hi;
    logic [31:0] pc;
    logic [31:0] data;
    int          digit;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [7:0]  exp_count;
  } vec_t;

  vec_t vecs [28];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (at negedges) for a fresh load of digit d: a dark cycle, then its anode.
  task automatic wait_lit(input int d);
    logic [7:0] target;
    int n;
    target = 8'h01 << d;
    target = ~target;
    n = 0;
    while (an !== 8'hFF && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (an !== target && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_lit timeout: digit %0d never lit, an=%h", d, an);
    end
  endtask

  task automatic wait_blank();
    int n;
    n = 0;
    while (an !== 8'hFF && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_blank timeout: an=%h", an);
    end
  endtask

  task automatic pulse(input logic [31:0] p, input logic [31:0] d);
    pc_in    = p;
    wb_data  = d;
    wb_valid = 1'b1;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  initial begin
    int lit_len;

    // {pulses, freeze, show_hi, pc, data, digit, seg, dp, count}
    vecs[0]  = '{1, 1'b0, 1'b0, 32'h0000_0044, 32'h0000_00A5, 0, 7'h12, 1'b1, 8'd1};
    vecs[1]  = '{0, 1'b0, 1'b0, 32'h0, 32'h0, 1, 7'h08, 1'b1, 8'd1};
    vecs[2]  = '{0, 1'b0, 1'b0, 32'h0, 32'h0, 2, 7'h40, 1'b1, 8'd1};
    vecs[3]  = '{0, 1'b0, 1'b0, 32'h0, 32'h0, 3, 7'h40, 1'b1, 8'd1};
    vecs[4]  = '{0, 1'b0, 1'b0, 32'h0, 32'h0, 4, 7'h19, 1'b0, 8'd1};
    vecs[5]  = '{0, 1'b0, 1'b0, 32'h0, 32'h0, 5, 7'h19, 1'b1, 8'd1};
    vecs[6]  = '{0, 1'b0, 1'b0, 32'h0, 32'h0, 6, 7'h40, 1'b1, 8'd1};
    vecs[7]  = '{0, 1'b0, 1'b0, 32'h0, 32'h0, 7, 7'h40, 1'b1, 8'd1};
    // frozen: three writebacks ignored
    vecs[8]  = '{3, 1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 7'h12, 1'b1, 8'd1};
    vecs[9]  = '{0, 1'b1, 1'b0, 32'h0, 32'h0, 4, 7'h19, 1'b0, 8'd1};
    // upper halves
    vecs[10] = '{1, 1'b0, 1'b1, 32'hBEEF_0044, 32'hDEAD_0000, 0, 7'h21, 1'b1, 8'd2};
    vecs[11] = '{0, 1'b0, 1'b1, 32'h0, 32'h0, 1, 7'h08, 1'b1, 8'd2};
    vecs[12] = '{0, 1'b0, 1'b1, 32'h0, 32'h0, 2, 7'h06, 1'b1, 8'd2};
    vecs[13] = '{0, 1'b0, 1'b1, 32'h0, 32'h0, 3, 7'h21, 1'b1, 8'd2};
    vecs[14] = '{0, 1'b0, 1'b1, 32'h0, 32'h0, 4, 7'h0E, 1'b0, 8'd2};
    vecs[15] = '{0, 1'b0, 1'b1, 32'h0, 32'h0, 5, 7'h06, 1'b1, 8'd2};
    vecs[16] = '{0, 1'b0, 1'b1, 32'h0, 32'h0, 6, 7'h06, 1'b1, 8'd2};
    vecs[17] = '{0, 1'b0, 1'b1, 32'h0, 32'h0, 7, 7'h03, 1'b1, 8'd2};
    // same capture, lower halves
    vecs[18] = '{0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 7'h40, 1'b1, 8'd2};
    vecs[19] = '{0, 1'b0, 1'b0, 32'h0, 32'h0, 4, 7'h19, 1'b0, 8'd2};
    // assorted nibbles
    vecs[20] = '{1, 1'b0, 1'b0, 32'h0000_89C7, 32'h0000_3B61, 0, 7'h79, 1'b1, 8'd3};
    vecs[21] = '{0, 1'b0, 1'b0, 32'h0, 32'h0, 1, 7'h02, 1'b1, 8'd3};
    vecs[22] = '{0, 1'b0, 1'b0, 32'h0, 32'h0, 2, 7'h03, 1'b1, 8'd3};
    vecs[23] = '{0, 1'b0, 1'b0, 32'h0, 32'h0, 3, 7'h30, 1'b1, 8'd3};
    vecs[24] = '{0, 1'b0, 1'b0, 32'h0, 32'h0, 4, 7'h78, 1'b0, 8'd3};
    vecs[25] = '{0, 1'b0, 1'b0, 32'h0, 32'h0, 5, 7'h46, 1'b1, 8'd3};
    vecs[26] = '{0, 1'b0, 1'b0, 32'h0, 32'h0, 6, 7'h10, 1'b1, 8'd3};
    vecs[27] = '{0, 1'b0, 1'b0, 32'h0, 32'h0, 7, 7'h00, 1'b1, 8'd3};

    reset    = 1'b1;
    wb_valid = 1'b0;
    pc_in    = 32'h0;
    wb_data  = 32'h0;
    freeze   = 1'b0;
    show_hi  = 1'b0;

    // Reset held three clocks
    repeat (3) @(negedge clk);
    check("reset an", 32'(an), 32'hFF);
    check("reset seg", 32'(seg), 32'h7F);
    check("reset dp", 32'(dp), 32'h1);
    check("reset wb_count", 32'(wb_count), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("first lit an", 32'(an), 32'hFE);
    check("first lit seg", 32'(seg), 32'h40);
    check("first lit dp", 32'(dp), 32'h1);
    $display("reset done: an=%h seg=%h dp=%b wb_count=%0d", an, seg, dp, wb_count);

    // Table-driven vectors
    for (int i = 0; i < 28; i++) begin
      freeze  = vecs[i].frz;
      show_hi = vecs[i].hi;
      for (int p = 0; p < vecs[i].pulses; p++) begin
        pulse(vecs[i].pc, vecs[i].data);
        @(negedge clk);
      end
      check($sformatf("vec%0d wb_count", i), 32'(wb_count), 32'(vecs[i].exp_count));
      wait_lit(vecs[i].digit);
      check($sformatf("vec%0d seg", i), 32'(seg), 32'(vecs[i].exp_seg));
      check($sformatf("vec%0d dp", i), 32'(dp), 32'(vecs[i].exp_dp));
      $display("vec %0d: digit=%0d an=%h seg=%h dp=%b wb_count=%0d", i, vecs[i].digit, an, seg, dp, wb_count);
    end
    freeze  = 1'b0;
    show_hi = 1'b0;

    // show_hi change mid-digit only applies at the next digit
    pulse(32'h0000_0000, 32'hDEAD_0000);
    check("cap4 wb_count", 32'(wb_count), 32'd4);
    wait_lit(0);
    check("hi mid before seg", 32'(seg), 32'h40);
    show_hi = 1'b1;
    @(negedge clk);
    check("hi mid held seg", 32'(seg), 32'h40);
    wait_lit(1);
    check("hi next digit seg", 32'(seg), 32'h08);
    $display("show_hi mid-digit: digit1 seg=%h", seg);

    // capture mid-digit only applies at the next digit
    pulse(32'h0000_0000, 32'h0C00_0000);
    check("cap mid held seg", 32'(seg), 32'h08);
    wait_lit(2);
    check("cap mid next seg", 32'(seg), 32'h46);
    wait_lit(3);
    check("cap mid digit3 seg", 32'(seg), 32'h40);
    $display("capture mid-digit: digit2 seg=%h", seg);

    // capture on the same edge as a load: load shows the old PC
    wait_blank();
    pulse(32'h0088_0000, 32'h0C00_0000);
    check("same-edge an", 32'(an), 32'hEF);
    check("same-edge old seg", 32'(seg), 32'h40);
    check("same-edge dp", 32'(dp), 32'h0);
    wait_lit(5);
    check("same-edge next seg", 32'(seg), 32'h00);
    $display("same-edge capture: digit5 seg=%h wb_count=%0d", seg, wb_count);

    // scan timing: 4 lit clocks, 1 dark clock
    wait_blank();
    @(negedge clk);
    lit_len = 0;
    while (an !== 8'hFF && lit_len < 20) begin
      lit_len++;
      @(negedge clk);
    end
    check("lit length", 32'(lit_len), 32'd4);
    @(negedge clk);
    check("blank length", 32'(an != 8'hFF), 32'h1);
    $display("timing: lit_len=%0d", lit_len);

    // digit 7 wraps to digit 0
    wait_lit(7);
    wait_blank();
    @(negedge clk);
    check("wrap to digit0 an", 32'(an), 32'hFE);
    $display("digit wrap: an=%h", an);

    // wb_count wraps 255 -> 0
    check("pre-wrap wb_count", 32'(wb_count), 32'd6);
    pc_in    = 32'h1;
    wb_data  = 32'h2;
    wb_valid = 1'b1;
    repeat (249) @(negedge clk);
    wb_valid = 1'b0;
    check("count 255", 32'(wb_count), 32'd255);
    pulse(32'h3, 32'h4);
    check("count wrap 0", 32'(wb_count), 32'd0);
    $display("count wrap: wb_count=%0d", wb_count);

    // reset while digit 6 lit; writebacks ignored during reset
    wait_lit(6);
    reset    = 1'b1;
    wb_valid = 1'b1;
    pc_in    = 32'hFFFF_FFFF;
    wb_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    check("midreset an", 32'(an), 32'hFF);
    check("midreset seg", 32'(seg), 32'h7F);
    check("midreset dp", 32'(dp), 32'h1);
    check("midreset wb_count", 32'(wb_count), 32'h0);
    @(negedge clk);
    check("midreset held wb_count", 32'(wb_count), 32'h0);
    reset    = 1'b0;
    wb_valid = 1'b0;
    @(negedge clk);
    check("post-reset an", 32'(an), 32'hFE);
    check("post-reset seg", 32'(seg), 32'h40);
    check("post-reset wb_count", 32'(wb_count), 32'h0);
    $display("mid-scan reset: an=%h seg=%h wb_count=%0d", an, seg, wb_count);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
